// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: single-write, dual-read integer register file for the
// 5-stage pipeline, with a per-register busy scoreboard for in-flight writes,
// a pending-write counter, a flush input and a parametrised reset preload.
// Optional feature macro: REGFILE_BYPASS_EN enables same-cycle write-to-read
// forwarding on both read ports. Without it, a same-cycle read-after-write
// returns the old contents and the pipeline has to stall one cycle.
module regfile_scoreboard #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned AW       = $clog2(NREGS),
    parameter int unsigned INIT_REG = 9,
    parameter logic [XLEN-1:0] INIT_VAL = XLEN'(6)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [AW-1:0]              A1,
    input  logic [AW-1:0]              A2,
    output logic [XLEN-1:0]            RD1,
    output logic [XLEN-1:0]            RD2,
    output logic                       busy1,
    output logic                       busy2,
    input  logic                       WE3,
    input  logic [AW-1:0]              A3,
    input  logic [XLEN-1:0]            WD3,
    input  logic                       issue_valid,
    input  logic [AW-1:0]              issue_rd,
    input  logic                       flush,
    output logic [$clog2(NREGS+1)-1:0] pending_cnt
);

    localparam int unsigned CW = $clog2(NREGS + 1);

    // Register 0 never busy, so NREGS-1 is the largest legal busy count.
    localparam logic [CW-1:0] CNT_MAX = CW'(NREGS - 1);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    logic write_en;
    logic set_en;
    logic cnt_inc;
    logic cnt_dec;

    // Qualify writeback and issue: anything aimed at register 0 is dropped.
    always_comb begin
        write_en = WE3 && (A3 != '0);
        set_en   = issue_valid && (issue_rd != '0);
    end

    // Work out the one-step change in the busy count from the pre-edge busy
    // bits. A set on a register that is being cleared in the same cycle keeps
    // it busy (new producer supersedes), so that clear must not decrement.
    always_comb begin
        cnt_inc = set_en && !busy[issue_rd];
        cnt_dec = write_en && busy[A3] && !(set_en && (issue_rd == A3));
    end

    // Register storage: async reset preload, then single-port writeback.
    // Register 0 is only ever loaded with zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                if ((INIT_REG != 0) && (i == INIT_REG))
                    regs[i] <= INIT_VAL;
                else
                    regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[A3] <= WD3;
        end
    end

    // Busy scoreboard: flush wipes everything, otherwise clear then set so
    // that a same-register set takes priority over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (write_en)
                busy[A3] <= 1'b0;
            if (set_en)
                busy[issue_rd] <= 1'b1;
        end
    end

    // Pending-write counter tracks popcount(busy) incrementally and
    // saturates at the largest reachable busy count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_cnt <= '0;
        end else if (flush) begin
            pending_cnt <= '0;
        end else if (cnt_inc && !cnt_dec) begin
            if (pending_cnt < CNT_MAX)
                pending_cnt <= pending_cnt + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            if (pending_cnt != '0)
                pending_cnt <= pending_cnt - 1'b1;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Read ports with write-through forwarding: a same-cycle writeback to the
    // addressed register is returned directly and reported as not busy.
    always_comb begin
        RD1   = regs[A1];
        busy1 = busy[A1];
        RD2   = regs[A2];
        busy2 = busy[A2];
        if (write_en && (A3 == A1)) begin
            RD1   = WD3;
            busy1 = 1'b0;
        end
        if (write_en && (A3 == A2)) begin
            RD2   = WD3;
            busy2 = 1'b0;
        end
    end
`else
    // Read ports without forwarding: plain combinational lookup of the
    // pre-edge register contents and busy bits.
    always_comb begin
        RD1   = regs[A1];
        busy1 = busy[A1];
        RD2   = regs[A2];
        busy2 = busy[A2];
    end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: table-driven, self-checking bench for
// regfile_scoreboard using an expected-result queue.
module tb_regfile_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int CW    = 6;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic            clk;
    logic            reset_n;
    logic [AW-1:0]   a1, a2, a3, issue_rd;
    logic [XLEN-1:0] rd1, rd2, wd3;
    logic            busy1, busy2, we3, issue_valid, flush;
    logic [CW-1:0]   pending_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            we;
        logic [AW-1:0]   a3;
        logic [XLEN-1:0] wd;
        logic            iv;
        logic [AW-1:0]   rd;
        logic            fl;
        logic [AW-1:0]   a1;
        logic [AW-1:0]   a2;
        logic [XLEN-1:0] e1;
        logic [XLEN-1:0] e2;
        logic            eb1;
        logic            eb2;
        logic [CW-1:0]   ecnt;
    } vec_t;

    typedef struct {
        int              row;
        logic [XLEN-1:0] e1;
        logic [XLEN-1:0] e2;
        logic            eb1;
        logic            eb2;
        logic [CW-1:0]   ecnt;
    } exp_t;

    vec_t vecs [20];
    exp_t exp_q [$];

    regfile_scoreboard dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .A1          (a1),
        .A2          (a2),
        .RD1         (rd1),
        .RD2         (rd2),
        .busy1       (busy1),
        .busy2       (busy2),
        .WE3         (we3),
        .A3          (a3),
        .WD3         (wd3),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .pending_cnt (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic we, int a3v, logic [XLEN-1:0] wd, logic iv, int rdv,
                                logic fl, int a1v, int a2v, logic [XLEN-1:0] e1,
                                logic [XLEN-1:0] e2, logic eb1, logic eb2, int ecnt);
        vec_t v;
        v.we = we;  v.a3 = AW'(a3v); v.wd = wd;
        v.iv = iv;  v.rd = AW'(rdv); v.fl = fl;
        v.a1 = AW'(a1v); v.a2 = AW'(a2v);
        v.e1 = e1;  v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
        v.ecnt = CW'(ecnt);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                               input logic [XLEN-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        we3 = 1'b0; a3 = '0; wd3 = '0;
        issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
    endtask

    // Drive one row just after a rising edge, queue its expectations, and
    // compare on the following falling edge.
    task automatic applyStimulus(input int row);
        exp_t e;
        @(posedge clk);
        #1;
        we3 = vecs[row].we; a3 = vecs[row].a3; wd3 = vecs[row].wd;
        issue_valid = vecs[row].iv; issue_rd = vecs[row].rd; flush = vecs[row].fl;
        a1 = vecs[row].a1; a2 = vecs[row].a2;
        e.row = row; e.e1 = vecs[row].e1; e.e2 = vecs[row].e2;
        e.eb1 = vecs[row].eb1; e.eb2 = vecs[row].eb2; e.ecnt = vecs[row].ecnt;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL row%0d scoreboard: got empty queue, want entry", row);
        end else begin
            e = exp_q.pop_front();
            checkOutput($sformatf("row%0d RD1", e.row), rd1, e.e1);
            checkOutput($sformatf("row%0d RD2", e.row), rd2, e.e2);
            checkOutput($sformatf("row%0d busy1", e.row), XLEN'(busy1), XLEN'(e.eb1));
            checkOutput($sformatf("row%0d busy2", e.row), XLEN'(busy2), XLEN'(e.eb2));
            checkOutput($sformatf("row%0d pending_cnt", e.row), XLEN'(pending_cnt), XLEN'(e.ecnt));
        end
    endtask

    task automatic checkResetState(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            a1 = AW'(i);
            a2 = AW'(NREGS - 1 - i);
            #1;
            checkOutput($sformatf("%s RD1[%0d]", tag, i), rd1, (i == 9) ? 32'd6 : 32'd0);
            checkOutput($sformatf("%s busy1[%0d]", tag, i), XLEN'(busy1), '0);
            checkOutput($sformatf("%s RD2[%0d]", tag, NREGS - 1 - i), rd2,
                        ((NREGS - 1 - i) == 9) ? 32'd6 : 32'd0);
            checkOutput($sformatf("%s busy2[%0d]", tag, NREGS - 1 - i), XLEN'(busy2), '0);
        end
        checkOutput($sformatf("%s pending_cnt", tag), XLEN'(pending_cnt), '0);
    endtask

    initial begin
        //          we a3 wd            iv rd fl a1 a2  RD1           RD2           b1 b2 cnt
        vecs[0]  = mk(0, 0, 32'h0,      0, 0, 0, 9, 0,  32'd6,        32'd0,        0, 0, 0);
        vecs[1]  = mk(1, 0, 32'hDEAD,   1, 0, 0, 0, 9,  32'd0,        32'd6,        0, 0, 0);
        vecs[2]  = mk(0, 0, 32'h0,      1, 5, 0, 0, 1,  32'd0,        32'd0,        0, 0, 0);
        vecs[3]  = mk(0, 0, 32'h0,      0, 0, 0, 5, 0,  32'd0,        32'd0,        1, 0, 1);
        vecs[4]  = mk(0, 0, 32'h0,      0, 0, 0, 5, 0,  32'd0,        32'd0,        1, 0, 1);
        vecs[5]  = mk(1, 5, 32'h1234,   0, 0, 0, 9, 0,  32'd6,        32'd0,        0, 0, 1);
        vecs[6]  = mk(0, 0, 32'h0,      1, 7, 0, 5, 5,  32'h1234,     32'h1234,     0, 0, 0);
        vecs[7]  = mk(0, 0, 32'h0,      1, 4, 0, 7, 0,  32'd0,        32'd0,        1, 0, 1);
        vecs[8]  = mk(0, 0, 32'h0,      0, 0, 0, 7, 4,  32'd0,        32'd0,        1, 1, 2);
        vecs[9]  = mk(1, 7, 32'd77,     1, 7, 0, 4, 9,  32'd0,        32'd6,        1, 0, 2);
        vecs[10] = mk(1, 4, 32'd44,     1, 3, 0, 7, 3,  32'd77,       32'd0,        1, 0, 2);
        vecs[11] = mk(0, 0, 32'h0,      1, 7, 0, 3, 4,  32'd0,        32'd44,       1, 0, 2);
        vecs[12] = mk(0, 0, 32'h0,      1, 1, 0, 7, 3,  32'd77,       32'd0,        1, 1, 2);
        vecs[13] = mk(0, 0, 32'h0,      1, 2, 0, 1, 2,  32'd0,        32'd0,        1, 0, 3);
        vecs[14] = mk(1, 2, 32'd9,      0, 0, 1, 1, 7,  32'd0,        32'd77,       1, 1, 4);
        vecs[15] = mk(0, 0, 32'h0,      1, 6, 1, 2, 7,  32'd9,        32'd77,       0, 0, 0);
        vecs[16] = mk(1, 1, 32'd11,     1, 1, 0, 6, 9,  32'd0,        32'd6,        0, 0, 0);
        vecs[17] = mk(1, 1, 32'd12,     1, 2, 0, 7, 2,  32'd77,       32'd9,        0, 0, 1);
        vecs[18] = mk(1, 6, 32'd66,     0, 0, 0, 1, 2,  32'd12,       32'd9,        0, 1, 1);
        vecs[19] = mk(0, 0, 32'h0,      0, 0, 0, 6, 2,  32'd66,       32'd9,        0, 1, 1);

        idleInputs();
        a1 = '0; a2 = '0;
        reset_n = 1'b0;
        #23;
        reset_n = 1'b1;
        checkResetState("reset");

        for (int r = 0; r < 20; r++)
            applyStimulus(r);

        // Same-cycle read-after-write on a busy register, with and without forwarding.
        @(posedge clk); #1;
        idleInputs();
        issue_valid = 1'b1; issue_rd = 5'd8; a1 = 5'd8; a2 = 5'd8;
        @(posedge clk); #1;
        idleInputs();
        we3 = 1'b1; a3 = 5'd8; wd3 = 32'hABCD;
        @(negedge clk);
        checkOutput("bypass RD1 same cycle", rd1, BYPASS ? 32'hABCD : 32'd0);
        checkOutput("bypass RD2 same cycle", rd2, BYPASS ? 32'hABCD : 32'd0);
        checkOutput("bypass busy1 same cycle", XLEN'(busy1), BYPASS ? 32'd0 : 32'd1);
        checkOutput("bypass busy2 same cycle", XLEN'(busy2), BYPASS ? 32'd0 : 32'd1);
        @(posedge clk); #1;
        idleInputs();
        @(negedge clk);
        checkOutput("bypass RD1 next cycle", rd1, 32'hABCD);
        checkOutput("bypass busy1 next cycle", XLEN'(busy1), 32'd0);
        checkOutput("bypass pending_cnt", XLEN'(pending_cnt), 32'd1);

        // Mid-cycle reset while a write and an issue are being presented.
        @(posedge clk); #1;
        we3 = 1'b1; a3 = 5'd9; wd3 = 32'hFFFF;
        issue_valid = 1'b1; issue_rd = 5'd9;
        #2;
        reset_n = 1'b0;
        @(posedge clk); #1;
        idleInputs();
        @(negedge clk);
        reset_n = 1'b1;
        checkResetState("midreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
